// File: rtl/fle_frac_gen2.sv
// Fracturable logic element: K-input LUT or two (K-1)-input LUTs with carry,
// two flops with scan, and a serially loaded configuration chain.
module fle_frac_gen2 #(
  parameter int unsigned K = 6
) (
  input  logic         fle_clk,
  input  logic         fle_reset,
  input  logic         scan_en,
  input  logic         scan_mode,
  input  logic [K-1:0] fle_in,
  input  logic         fle_cin,
  input  logic         fle_sc_in,
  input  logic [1:0]   fle_sr,
  input  logic [1:0]   fle_ce,
  input  logic         cfg_en,
  input  logic         cfg_din,
  output logic [1:0]   fle_out,
  output logic         fle_o6,
  output logic         fle_cout,
  output logic         fle_sc_out,
  output logic         cfg_dout,
  output logic         cfg_valid
);

  localparam int unsigned LutN  = 2 ** K;
  localparam int unsigned CFG_W = LutN + 8;
  localparam int unsigned CntW  = $clog2(CFG_W + 1);

  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       q_q, q_d;

  logic [LutN-1:0]  mask;
  logic             frac, carry_en;
  logic [1:0]       bypass, sr_use, ce_use;
  logic             full, lut_a, lut_b, fractured, sum;
  logic [1:0]       d;
  logic             cnt_full;

  always_comb begin
    mask     = cfg_q[LutN-1:0];
    frac     = cfg_q[LutN];
    carry_en = cfg_q[LutN+1];
    bypass   = cfg_q[LutN+3:LutN+2];
    sr_use   = cfg_q[LutN+5:LutN+4];
    ce_use   = cfg_q[LutN+7:LutN+6];
  end

  // Config chain and load counter; a shift while fully loaded restarts the count.
  always_comb begin
    cnt_full = (cnt_q == CntW'(CFG_W));
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    if (cfg_en) begin
      cfg_d = {cfg_q[CFG_W-2:0], cfg_din};
      cnt_d = cnt_full ? CntW'(1) : cnt_q + CntW'(1);
    end
  end

  assign cfg_valid = cnt_full & ~cfg_en;
  assign cfg_dout  = cfg_q[CFG_W-1];

  always_comb begin
    full      = mask[fle_in];
    lut_a     = mask[{1'b0, fle_in[K-2:0]}];
    lut_b     = mask[{1'b1, fle_in[K-2:0]}];
    fractured = frac | carry_en;
    sum       = lut_a ^ fle_cin;
    d[0]      = carry_en ? sum : (fractured ? lut_a : full);
    d[1]      = fractured ? lut_b : full;
  end

  always_comb begin
    q_d = q_q;
    if (!cfg_valid) begin
      q_d = '0;
    end else if (scan_en) begin
      q_d = {q_q[0], fle_sc_in};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sr_use[i] & fle_sr[i]) begin
          q_d[i] = 1'b0;
        end else if (!ce_use[i] | fle_ce[i]) begin
          q_d[i] = d[i];
        end
      end
    end
  end

  always_ff @(posedge fle_clk) begin
    if (fle_reset) begin
      cfg_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  // Functional outputs are silenced until a complete configuration is present.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fle_out[i] = cfg_valid & ((bypass[i] & ~scan_mode) ? d[i] : q_q[i]);
    end
    fle_o6     = cfg_valid & d[1];
    fle_cout   = cfg_valid & carry_en & (lut_a ? fle_cin : lut_b);
    fle_sc_out = q_q[1];
  end

endmodule

// File: tb/tb_fle_frac_gen2.sv
// Bench for fle_frac_gen2: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_fle_frac_gen2;

  localparam int K = 6;

  logic         fle_clk, fle_reset, scan_en, scan_mode;
  logic [K-1:0] fle_in;
  logic         fle_cin, fle_sc_in, cfg_en, cfg_din;
  logic [1:0]   fle_sr, fle_ce;
  logic [1:0]   fle_out;
  logic         fle_o6, fle_cout, fle_sc_out, cfg_dout, cfg_valid;

  fle_frac_gen2 #(.K(K)) dut (
    .fle_clk    (fle_clk),
    .fle_reset  (fle_reset),
    .scan_en    (scan_en),
    .scan_mode  (scan_mode),
    .fle_in     (fle_in),
    .fle_cin    (fle_cin),
    .fle_sc_in  (fle_sc_in),
    .fle_sr     (fle_sr),
    .fle_ce     (fle_ce),
    .cfg_en     (cfg_en),
    .cfg_din    (cfg_din),
    .fle_out    (fle_out),
    .fle_o6     (fle_o6),
    .fle_cout   (fle_cout),
    .fle_sc_out (fle_sc_out),
    .cfg_dout   (cfg_dout),
    .cfg_valid  (cfg_valid)
  );

  initial begin
    fle_clk = 1'b0;
    forever #5 fle_clk = ~fle_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: config as a plain bit vector, load count as an integer.
  logic [71:0] m_cfg;
  int          m_cnt;
  logic [1:0]  m_q;

  function automatic bit m_valid();
    return (m_cnt == 72) && !cfg_en;
  endfunction

  // Returns {carry_out, o6, d1, d0} before output gating.
  function automatic logic [3:0] m_raw();
    logic [63:0] mask;
    int          lo;
    logic        full, la, lb, fr, cen;
    mask = m_cfg[63:0];
    lo   = int'(fle_in[4:0]);
    full = mask[int'(fle_in)];
    la   = mask[lo];
    lb   = mask[lo + 32];
    cen  = m_cfg[65];
    fr   = m_cfg[64] | cen;
    return {cen & (la ? fle_cin : lb), fr ? lb : full, fr ? lb : full,
            cen ? (la ^ fle_cin) : (fr ? la : full)};
  endfunction

  function automatic logic [6:0] m_out();
    logic [3:0] r;
    logic [1:0] o;
    bit         v;
    r = m_raw();
    v = m_valid();
    for (int i = 0; i < 2; i++)
      o[i] = v ? ((m_cfg[66+i] && !scan_mode) ? r[i] : m_q[i]) : 1'b0;
    return {o, v & r[2], v & r[3], m_q[1], m_cfg[71], v};
  endfunction

  always @(posedge fle_clk) begin
    if (fle_reset) begin
      m_cfg <= '0;
      m_cnt <= 0;
      m_q   <= '0;
    end else begin
      if (cfg_en) begin
        m_cfg <= {m_cfg[70:0], cfg_din};
        m_cnt <= (m_cnt == 72) ? 1 : m_cnt + 1;
      end
      if (!m_valid()) m_q <= '0;
      else if (scan_en) m_q <= {m_q[0], fle_sc_in};
      else begin
        for (int i = 0; i < 2; i++) begin
          if (m_cfg[68+i] && fle_sr[i]) m_q[i] <= 1'b0;
          else if (!m_cfg[70+i] || fle_ce[i]) m_q[i] <= m_raw()[i];
        end
      end
    end
  end

  always @(negedge fle_clk) begin
    if (chk_en)
      chk("cycle", {1'b0, fle_out, fle_o6, fle_cout, fle_sc_out, cfg_dout, cfg_valid},
          {1'b0, m_out()});
  end

  task automatic tick();
    @(posedge fle_clk);
    #1;
  endtask

  task automatic load_cfg(input logic [71:0] v);
    for (int i = 71; i >= 0; i--) begin
      cfg_en  = 1'b1;
      cfg_din = v[i];
      tick();
    end
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  function automatic logic [71:0] mk(input logic [1:0] ceu, input logic [1:0] sru,
                                     input logic [1:0] byp, input logic cen,
                                     input logic frac, input logic [63:0] mask);
    return {ceu, sru, byp, cen, frac, mask};
  endfunction

  logic [71:0] v25, v26, v27, vr;
  logic [63:0] m26;

  initial begin
    fle_reset = 1'b1; scan_en = 1'b0; scan_mode = 1'b0; fle_in = '0; fle_cin = 1'b0;
    fle_sc_in = 1'b0; fle_sr = '0; fle_ce = '0; cfg_en = 1'b0; cfg_din = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    fle_reset = 1'b0;
    #1;
    chk("reset_outs", {1'b0, fle_out, fle_o6, fle_cout, fle_sc_out, cfg_dout, cfg_valid}, 8'h00);

    // Single-minterm LUT with both bypasses on.
    v25 = mk(2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 64'h8000_0000_0000_0000);
    load_cfg(v25);
    fle_in = 6'h3F;
    #1;
    chk("valid_after_load", cfg_valid, 1);
    chk("o6_3f", fle_o6, 1);
    chk("out_3f_bypass", fle_out, 2'b11);
    fle_in = 6'h3E;
    #1;
    chk("o6_3e", fle_o6, 0);
    chk("out_3e_bypass", fle_out, 2'b00);

    // Scan shift with scan_mode forcing the registered path.
    fle_in = 6'h3F; scan_en = 1'b1; scan_mode = 1'b1; fle_sc_in = 1'b1;
    tick();
    fle_sc_in = 1'b0;
    tick();
    chk("scan_sc_out", fle_sc_out, 1);
    chk("scan_out_is_q", fle_out, 2'b10);
    scan_en = 1'b0; scan_mode = 1'b0;

    // One extra shift invalidates; 71 more restore.
    cfg_en = 1'b1; cfg_din = v25[71];
    #1;
    chk("pulse_invalid", cfg_valid, 0);
    chk("pulse_gated", {fle_out, fle_o6}, 3'b000);
    tick();
    cfg_en = 1'b0;
    #1;
    chk("after_pulse_invalid", cfg_valid, 0);
    for (int i = 70; i >= 1; i--) begin
      cfg_en = 1'b1; cfg_din = v25[i];
      tick();
    end
    cfg_en = 1'b0;
    #1;
    chk("after_70_invalid", cfg_valid, 0);
    cfg_en = 1'b1; cfg_din = v25[0];
    tick();
    cfg_en = 1'b0;
    #1;
    chk("after_71_valid", cfg_valid, 1);
    chk("after_71_o6", fle_o6, 1);

    // Carry chain: lower half XOR, upper half AND of in0/in1.
    for (int j = 0; j < 32; j++) begin
      m26[j]      = j[0] ^ j[1];
      m26[j + 32] = j[0] & j[1];
    end
    v26 = mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, m26);
    load_cfg(v26);
    fle_in = 6'b000011; fle_cin = 1'b1;
    #1;
    chk("carry_cout", fle_cout, 1);
    chk("carry_out_pre", fle_out, 2'b00);
    tick();
    chk("carry_sum_reg", fle_out, 2'b11);
    fle_cin = 1'b0;

    // Clock enable and synchronous clear.
    v27 = mk(2'b11, 2'b10, 2'b00, 1'b0, 1'b1, 64'hFFFF_FFFF_AAAA_AAAA);
    load_cfg(v27);
    fle_ce = 2'b11; fle_in = 6'd0;
    tick();
    chk("ce_load", fle_out, 2'b10);
    fle_ce = 2'b00; fle_in = 6'd1;
    tick();
    chk("ce_hold", fle_out, 2'b10);
    fle_ce = 2'b11; fle_sr = 2'b10;
    tick();
    chk("sr_clear_q1", fle_out, 2'b01);
    fle_sr = 2'b00; fle_ce = 2'b00;

    // Reset mid-load discards the partial configuration.
    for (int i = 71; i >= 42; i--) begin
      cfg_en = 1'b1; cfg_din = v25[i];
      tick();
    end
    fle_reset = 1'b1;
    tick();
    fle_reset = 1'b0; cfg_en = 1'b0; fle_in = 6'h3F;
    #1;
    chk("midload_reset", {1'b0, fle_out, fle_o6, fle_cout, cfg_dout, cfg_valid}, 8'h00);
    load_cfg(v25);
    #1;
    chk("reload_o6", fle_o6, 1);
    chk("reload_out", fle_out, 2'b11);

    // Randomized traffic, model-checked every cycle.
    for (int c = 0; c < 20; c++) begin
      vr = {$urandom(), $urandom(), $urandom()};
      load_cfg(vr);
      for (int t = 0; t < 150; t++) begin
        fle_in    = K'($urandom());
        fle_cin   = 1'($urandom());
        fle_sc_in = 1'($urandom());
        fle_sr    = 2'($urandom());
        fle_ce    = 2'($urandom());
        scan_en   = ($urandom_range(0, 7) == 0);
        scan_mode = ($urandom_range(0, 3) == 0);
        cfg_en    = ($urandom_range(0, 63) == 0);
        cfg_din   = 1'($urandom());
        fle_reset = ($urandom_range(0, 299) == 0);
        tick();
      end
      fle_reset = 1'b0; cfg_en = 1'b0; scan_en = 1'b0; scan_mode = 1'b0;
    end

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
